// File: rtl/line_clipper_if.sv
// Handshake and coordinate bundle for line_clipper: input line/window transfer and clipped result.
interface line_clipper_if #(
    parameter int CW = 16
);
    logic signed [CW-1:0] i_x1, i_y1, i_x2, i_y2;
    logic signed [CW-1:0] i_xmin, i_xmax, i_ymin, i_ymax;
    logic                 i_valid;
    logic                 o_ready;
    logic signed [CW-1:0] o_x1, o_y1, o_x2, o_y2;
    logic                 o_visible;
    logic                 o_valid;
    logic                 i_ready;

    modport master (
        output i_x1, i_y1, i_x2, i_y2, i_xmin, i_xmax, i_ymin, i_ymax, i_valid, i_ready,
        input  o_ready, o_x1, o_y1, o_x2, o_y2, o_visible, o_valid
    );

    modport slave (
        input  i_x1, i_y1, i_x2, i_y2, i_xmin, i_xmax, i_ymin, i_ymax, i_valid, i_ready,
        output o_ready, o_x1, o_y1, o_x2, o_y2, o_visible, o_valid
    );
endinterface

// File: rtl/line_clipper.sv
// Cohen-Sutherland line clipper with a bit-serial restoring divider for edge intersections.
// Define LINE_CLIPPER_ROUND_EN to round intersection quotients to nearest instead of truncating.
module line_clipper #(
    parameter int CW       = 16,
    parameter int MAX_PASS = 8
) (
    input logic           clk,
    input logic           rst,
    line_clipper_if.slave bus
);
    localparam int PW     = 2 * CW + 2;
    localparam int CNT_W  = $clog2(PW + 1);
    localparam int PASS_W = $clog2(MAX_PASS + 1);

    typedef enum logic [2:0] {IDLE, CODE, MUL, DIV, UPD, DONE} state_t;

    state_t               state_q, state_d;
    logic signed [CW-1:0] x1_q, y1_q, x2_q, y2_q;
    logic signed [CW-1:0] x1_d, y1_d, x2_d, y2_d;
    logic signed [CW-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic signed [CW-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
    logic                 visible_q, visible_d;
    logic [PASS_W-1:0]    pass_q, pass_d;
    logic                 sel_q, sel_d;
    logic                 xedge_q, xedge_d;
    logic signed [CW-1:0] edge_val_q, edge_val_d;
    logic [PW-1:0]        dq_q, dq_d;
    logic [CW:0]          rem_q, rem_d;
    logic [CW:0]          dvs_q, dvs_d;
    logic                 neg_q, neg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [3:0]           code1, code2, code_sel;
    logic signed [CW-1:0] xs, ys, other_new;
    logic signed [CW:0]   dx, dy, d_other, d_edge, diff;
    logic signed [PW-1:0] prod_a, prod_b, prod;
    logic [PW-1:0]        prod_mag, q_mag, q_signed;
    logic [CW:0]          edge_mag;
    logic [CW+1:0]        rem_shift, rem_sub;
    logic                 take;
    logic                 unused_bits;

    function automatic logic [3:0] outcode(input logic signed [CW-1:0] x, y, xmin, xmax, ymin, ymax);
        outcode = {y < ymin, y > ymax, x > xmax, x < xmin};
    endfunction

    // Datapath: outcodes, intersection product, one restoring-division step and the final quotient.
    always_comb begin
        code1    = outcode(x1_q, y1_q, xmin_q, xmax_q, ymin_q, ymax_q);
        code2    = outcode(x2_q, y2_q, xmin_q, xmax_q, ymin_q, ymax_q);
        code_sel = (code1 != 4'b0) ? code1 : code2;
        xs       = sel_q ? x2_q : x1_q;
        ys       = sel_q ? y2_q : y1_q;
        dx       = {x2_q[CW-1], x2_q} - {x1_q[CW-1], x1_q};
        dy       = {y2_q[CW-1], y2_q} - {y1_q[CW-1], y1_q};
        if (xedge_q) begin
            d_other = dy;
            d_edge  = dx;
            diff    = {edge_val_q[CW-1], edge_val_q} - {xs[CW-1], xs};
        end else begin
            d_other = dx;
            d_edge  = dy;
            diff    = {edge_val_q[CW-1], edge_val_q} - {ys[CW-1], ys};
        end
        prod_a    = {{(PW-CW-1){d_other[CW]}}, d_other};
        prod_b    = {{(PW-CW-1){diff[CW]}}, diff};
        prod      = prod_a * prod_b;
        prod_mag  = prod[PW-1] ? -prod : prod;
        edge_mag  = d_edge[CW] ? -d_edge : d_edge;
        rem_shift = {rem_q, dq_q[PW-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        take      = (rem_shift >= {1'b0, dvs_q});
        q_mag     = dq_q;
`ifdef LINE_CLIPPER_ROUND_EN
        if ({rem_q, 1'b0} >= {1'b0, dvs_q}) begin
            q_mag = dq_q + PW'(1);
        end
`else
`endif
        if (dvs_q == '0) begin
            q_mag = '0;
        end
        q_signed    = neg_q ? -q_mag : q_mag;
        other_new   = (xedge_q ? ys : xs) + q_signed[CW-1:0];
        unused_bits = ^{q_signed[PW-1:CW], rem_sub[CW+1]};
    end

    // Control: handshake, accept/reject decisions and per-pass sequencing.
    always_comb begin
        state_d    = state_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymin_d     = ymin_q;
        ymax_d     = ymax_q;
        visible_d  = visible_q;
        pass_d     = pass_q;
        sel_d      = sel_q;
        xedge_d    = xedge_q;
        edge_val_d = edge_val_q;
        dq_d       = dq_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        neg_d      = neg_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    x1_d      = bus.i_x1;
                    y1_d      = bus.i_y1;
                    x2_d      = bus.i_x2;
                    y2_d      = bus.i_y2;
                    xmin_d    = bus.i_xmin;
                    xmax_d    = bus.i_xmax;
                    ymin_d    = bus.i_ymin;
                    ymax_d    = bus.i_ymax;
                    pass_d    = '0;
                    visible_d = 1'b0;
                    state_d   = CODE;
                end
            end
            CODE: begin
                if (code1 == 4'b0 && code2 == 4'b0) begin
                    visible_d = 1'b1;
                    state_d   = DONE;
                end else if ((code1 & code2) != 4'b0 || xmin_q > xmax_q || ymin_q > ymax_q) begin
                    visible_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    sel_d = (code1 == 4'b0);
                    if (code_sel[0]) begin
                        xedge_d    = 1'b1;
                        edge_val_d = xmin_q;
                    end else if (code_sel[1]) begin
                        xedge_d    = 1'b1;
                        edge_val_d = xmax_q;
                    end else if (code_sel[3]) begin
                        xedge_d    = 1'b0;
                        edge_val_d = ymin_q;
                    end else begin
                        xedge_d    = 1'b0;
                        edge_val_d = ymax_q;
                    end
                    state_d = MUL;
                end
            end
            MUL: begin
                dq_d    = prod_mag;
                rem_d   = '0;
                dvs_d   = edge_mag;
                neg_d   = prod[PW-1] ^ d_edge[CW];
                cnt_d   = CNT_W'(PW);
                state_d = DIV;
            end
            DIV: begin
                rem_d = take ? rem_sub[CW:0] : rem_shift[CW:0];
                dq_d  = {dq_q[PW-2:0], take};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = UPD;
                end
            end
            UPD: begin
                if (xedge_q) begin
                    if (sel_q) begin
                        x2_d = edge_val_q;
                        y2_d = other_new;
                    end else begin
                        x1_d = edge_val_q;
                        y1_d = other_new;
                    end
                end else begin
                    if (sel_q) begin
                        y2_d = edge_val_q;
                        x2_d = other_new;
                    end else begin
                        y1_d = edge_val_q;
                        x1_d = other_new;
                    end
                end
                pass_d = pass_q + PASS_W'(1);
                if (pass_d == PASS_W'(MAX_PASS)) begin
                    visible_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    state_d = CODE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            visible_q  <= 1'b0;
            pass_q     <= '0;
            sel_q      <= 1'b0;
            xedge_q    <= 1'b0;
            edge_val_q <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            xmin_q     <= xmin_d;
            xmax_q     <= xmax_d;
            ymin_q     <= ymin_d;
            ymax_q     <= ymax_d;
            visible_q  <= visible_d;
            pass_q     <= pass_d;
            sel_q      <= sel_d;
            xedge_q    <= xedge_d;
            edge_val_q <= edge_val_d;
            dq_q       <= dq_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            neg_q      <= neg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_x1      = x1_q;
    assign bus.o_y1      = y1_q;
    assign bus.o_x2      = x2_q;
    assign bus.o_y2      = y2_q;
    assign bus.o_visible = visible_q;
    assign bus.o_valid   = (state_q == DONE);
    assign bus.o_ready   = (state_q == IDLE);
endmodule

// File: doc/line_clipper.md
LINE_CLIPPER -- requirements
Module: line_clipper

Interface
REQ-001 Parameter CW, default 16: signed coordinate width in bits (range 8..24).
REQ-002 Parameter MAX_PASS, default 8: limit on intersection passes per line before a forced reject.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 i_x1, i_y1, i_x2, i_y2  in  CW each  signed line endpoints.
REQ-006 i_xmin, i_xmax, i_ymin, i_ymax  in  CW each  signed clip window, inclusive bounds.
REQ-007 i_valid  in  1 / o_ready  out  1  input handshake; a transfer occurs when both are high.
REQ-008 o_x1, o_y1, o_x2, o_y2  out  CW each  signed clipped endpoints.
REQ-009 o_visible  out  1  high when the line is accepted, low when rejected.
REQ-010 o_valid  out  1 / i_ready  in  1  output handshake.

Function
REQ-011 Outcodes: LEFT=0001 (x<xmin), RIGHT=0010 (x>xmax), BOTTOM=0100 (y>ymax), TOP=1000 (y<ymin).
REQ-012 FSM states: IDLE, CODE, MUL, DIV, UPD, DONE.
REQ-013 o_ready SHALL be high only in IDLE; a transfer latches the endpoints and the window and enters CODE.
REQ-014 CODE: compute both outcodes, then:
- both zero -> DONE, visible=1.
- bitwise AND nonzero, or xmin>xmax, or ymin>ymax -> DONE, visible=0.
- otherwise -> MUL.
REQ-015 Endpoint selection: clip endpoint 1 if its outcode is nonzero, else endpoint 2.
REQ-016 Edge priority within the selected endpoint: LEFT, RIGHT, TOP, BOTTOM.
REQ-017 MUL: form product P = d_other * (edge - coord) at 2*CW+2 bits signed, where d_other is dy for x-edges and dx for y-edges.
REQ-018 DIV: compute q = P / d_edge with a sequential restoring divider on magnitudes, one quotient bit per cycle, 2*CW+2 cycles; apply the sign afterwards.
REQ-019 UPD: write the clipped coordinate as edge, the other coordinate as other+q truncated to CW, increment the pass counter, then return to CODE.
REQ-020 Pass counter reaching MAX_PASS in UPD -> DONE, visible=0.
REQ-021 dx/dy SHALL be taken from the current (already partially clipped) endpoints on every pass.
REQ-022 Dividing by zero is unreachable by construction; the divider SHALL still return q=0 if d_edge=0.
REQ-023 DONE: o_valid high and outputs stable until i_ready is sampled high; that cycle returns to IDLE.
REQ-024 Trivial accept/reject latency: o_valid asserted 2 cycles after the input transfer.
REQ-025 Each clip pass adds 2*CW+5 cycles (CODE + MUL + DIV + UPD).
REQ-026 On reject, o_x*/o_y* SHALL carry the last working coordinates.

Reset
REQ-027 rst SHALL immediately force IDLE, o_ready=1, o_valid=0, o_visible=0, o_x*/o_y*=0, pass counter=0, divider cleared.
REQ-028 rst asserted mid-operation SHALL discard the line in progress; no o_valid is produced for it.

Configuration
REQ-029 Macro LINE_CLIPPER_ROUND_EN defined: q SHALL be rounded to nearest, halves away from zero (remainder*2 >= |divisor| increments |q|).
REQ-030 Macro LINE_CLIPPER_ROUND_EN undefined: q SHALL be truncated toward zero; latency is identical in both builds.

Verification (CW=16, window 0..799 x 0..479)
REQ-031 (10,10)-(100,200) -> visible=1, unchanged, o_valid 2 cycles after transfer.
REQ-032 (-100,240)-(900,240) -> visible=1, (0,240)-(799,240), after 2 passes.
REQ-033 (-10,5)-(-20,50) -> visible=0 in 2 cycles; (-100,-100)-(900,900) -> visible=1, (0,0)-(479,479).
REQ-034 (-1,0)-(1,3) -> (0,2)-(1,3) with LINE_CLIPPER_ROUND_EN, (0,1)-(1,3) without.
REQ-035 Hold i_ready=0 for 10 cycles in DONE -> outputs stable, o_ready=0; the next line is accepted only after the handshake completes.
REQ-036 Assert rst during DIV -> all outputs at reset values on the next clock edge, no o_valid; the following line (10,10)-(20,20) clips correctly.
